// File: rtl/attn_pkg.sv
// Shared constants and state encoding for the attention control sequencer.
package attn_pkg;

    localparam int ATTN_N       = 8;
    localparam int ATTN_AW      = 6;
    localparam int ATTN_MAC_LAT = 2;

    localparam logic OP_QK = 1'b0;
    localparam logic OP_SV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_QK,
        ST_QK_WAIT,
        ST_SV,
        ST_SV_WAIT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/attn_idx_walker.sv
// Nested i/j/k index walker (k innermost), shared by the score and output phases.
module attn_idx_walker #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          k_last,
    output logic          all_last
);

    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    assign k_last   = (k == IDX_MAX);
    assign all_last = k_last && (j == IDX_MAX) && (i == IDX_MAX);

    // Counters wrap modulo N, so a complete walk leaves them back at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (step) begin
            k <= k + 1'b1;
            if (k_last) begin
                j <= j + 1'b1;
                if (j == IDX_MAX)
                    i <= i + 1'b1;
            end
        end
    end

endmodule

// File: rtl/attn_sequencer.sv
// Load / Q*K^T / S*V scheduler for the single-MAC attention datapath.
module attn_sequencer
    import attn_pkg::*;
#(
    parameter int N       = ATTN_N,
    parameter int AW      = ATTN_AW,
    parameter int MAC_LAT = ATTN_MAC_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          ld_we,
    output logic [AW-1:0] ld_addr,
    output logic          op_sel,
    output logic [AW-1:0] rd_a_addr,
    output logic [AW-1:0] rd_b_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic          done,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          fin,
    output logic          err_overrun
);

    localparam int IW = $clog2(N);
    localparam int WW = $clog2(MAC_LAT + 1);
    localparam logic [AW-1:0] LOAD_LAST = AW'(N * N - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAC_LAT - 1);

    state_t        state, next_state;
    logic [AW-1:0] load_cnt;
    logic [WW-1:0] wait_cnt;
    logic [IW-1:0] i, j, k;
    logic          k_last, all_last;
    logic          loading, ld_accept, issuing, wait_done, walk_start;
    logic          dl_vld  [MAC_LAT];
    logic          dl_sv   [MAC_LAT];
    logic [AW-1:0] dl_addr [MAC_LAT];

    assign loading    = (state == ST_IDLE) || (state == ST_LOAD);
    assign ld_accept  = en && loading;
    assign issuing    = (state == ST_QK) || (state == ST_SV);
    assign wait_done  = (wait_cnt == WAIT_LAST);
    assign walk_start = (state == ST_IDLE);

    attn_idx_walker #(.N(N), .IW(IW)) u_walker (
        .clk      (clk),
        .reset    (reset),
        .start    (walk_start),
        .step     (issuing),
        .i        (i),
        .j        (j),
        .k        (k),
        .k_last   (k_last),
        .all_last (all_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (en) next_state = ST_LOAD;
            ST_LOAD:    if (en && load_cnt == LOAD_LAST) next_state = ST_QK;
            ST_QK:      if (all_last) next_state = ST_QK_WAIT;
            ST_QK_WAIT: if (wait_done) next_state = ST_SV;
            ST_SV:      if (all_last) next_state = ST_SV_WAIT;
            ST_SV_WAIT: if (wait_done) next_state = ST_FIN;
            ST_FIN:     next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            load_cnt <= '0;
        else if (ld_accept)
            load_cnt <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + 1'b1;
    end

    // Sticky overrun flag; only a fresh run start clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_overrun <= 1'b0;
        else if (state == ST_IDLE && en)
            err_overrun <= 1'b0;
        else if (en && !loading)
            err_overrun <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state == ST_QK_WAIT || state == ST_SV_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Result tags travel MAC_LAT cycles alongside the MAC pipeline, across phase boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MAC_LAT; s++) begin
                dl_vld[s]  <= 1'b0;
                dl_sv[s]   <= 1'b0;
                dl_addr[s] <= '0;
            end
        end else begin
            dl_vld[0]  <= issuing && k_last;
            dl_sv[0]   <= (state == ST_SV);
            dl_addr[0] <= {i, j};
            for (int s = 1; s < MAC_LAT; s++) begin
                dl_vld[s]  <= dl_vld[s-1];
                dl_sv[s]   <= dl_sv[s-1];
                dl_addr[s] <= dl_addr[s-1];
            end
        end
    end

    always_comb begin
        ld_we     = ld_accept && reset;
        ld_addr   = load_cnt;
        op_sel    = OP_QK;
        rd_a_addr = '0;
        rd_b_addr = '0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        busy      = (state != ST_IDLE);
        fin       = (state == ST_FIN);
        s_we      = dl_vld[MAC_LAT-1] && !dl_sv[MAC_LAT-1];
        done      = dl_vld[MAC_LAT-1] && dl_sv[MAC_LAT-1];
        s_addr    = s_we ? dl_addr[MAC_LAT-1] : '0;
        out_addr  = done ? dl_addr[MAC_LAT-1] : '0;
        case (state)
            ST_QK: begin
                mac_en    = 1'b1;
                mac_clr   = (k == '0);
                rd_a_addr = {i, k};
                rd_b_addr = {j, k};
            end
            ST_SV: begin
                op_sel    = OP_SV;
                mac_en    = 1'b1;
                mac_clr   = (k == '0);
                rd_a_addr = {i, k};
                rd_b_addr = {k, j};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_attn_sequencer.sv
// Directed self-checking bench for attn_sequencer: vector table plus hand-built corner runs.
module tb_attn_sequencer;

    localparam int NN   = 64;
    localparam int NVEC = 21;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       ld_we, op_sel, mac_clr, mac_en, s_we, done, busy, fin, err_overrun;
    logic [5:0] ld_addr, rd_a_addr, rd_b_addr, s_addr, out_addr;

    int n_cmp = 0;
    int n_bad = 0;

    attn_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .op_sel      (op_sel),
        .rd_a_addr   (rd_a_addr),
        .rd_b_addr   (rd_b_addr),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .s_we        (s_we),
        .s_addr      (s_addr),
        .done        (done),
        .out_addr    (out_addr),
        .busy        (busy),
        .fin         (fin),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic en;
        logic ld_we;
        int   ld_addr;
        logic busy;
        logic mac_en;
        logic mac_clr;
        logic op_sel;
        int   rd_a;
        int   rd_b;
        logic s_we;
        int   s_addr;
        logic done;
        int   out_addr;
        logic fin;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mkVec(int cyc, logic e, logic lw, int la, logic b, logic me,
                                   logic mc, logic os, int ra, int rb, logic sw, int sa,
                                   logic d, int oa, logic f);
        vec_t v;
        v.cyc = cyc; v.en = e; v.ld_we = lw; v.ld_addr = la; v.busy = b;
        v.mac_en = me; v.mac_clr = mc; v.op_sel = os; v.rd_a = ra; v.rd_b = rb;
        v.s_we = sw; v.s_addr = sa; v.done = d; v.out_addr = oa; v.fin = f;
        return v;
    endfunction

    task automatic applyStimulus(input logic e);
        en = e;
    endtask

    task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, ".ld_we"},       -1, 32'(ld_we), 0);
        checkOutput({tag, ".ld_addr"},     -1, 32'(ld_addr), 0);
        checkOutput({tag, ".op_sel"},      -1, 32'(op_sel), 0);
        checkOutput({tag, ".rd_a"},        -1, 32'(rd_a_addr), 0);
        checkOutput({tag, ".rd_b"},        -1, 32'(rd_b_addr), 0);
        checkOutput({tag, ".mac_clr"},     -1, 32'(mac_clr), 0);
        checkOutput({tag, ".mac_en"},      -1, 32'(mac_en), 0);
        checkOutput({tag, ".s_we"},        -1, 32'(s_we), 0);
        checkOutput({tag, ".s_addr"},      -1, 32'(s_addr), 0);
        checkOutput({tag, ".done"},        -1, 32'(done), 0);
        checkOutput({tag, ".out_addr"},    -1, 32'(out_addr), 0);
        checkOutput({tag, ".busy"},        -1, 32'(busy), 0);
        checkOutput({tag, ".fin"},         -1, 32'(fin), 0);
        checkOutput({tag, ".err_overrun"}, -1, 32'(err_overrun), 0);
    endtask

    task automatic checkVec(input vec_t v);
        checkOutput("tbl.ld_we",    v.cyc, 32'(ld_we),     32'(v.ld_we));
        checkOutput("tbl.ld_addr",  v.cyc, 32'(ld_addr),   v.ld_addr);
        checkOutput("tbl.busy",     v.cyc, 32'(busy),      32'(v.busy));
        checkOutput("tbl.mac_en",   v.cyc, 32'(mac_en),    32'(v.mac_en));
        checkOutput("tbl.mac_clr",  v.cyc, 32'(mac_clr),   32'(v.mac_clr));
        checkOutput("tbl.op_sel",   v.cyc, 32'(op_sel),    32'(v.op_sel));
        checkOutput("tbl.rd_a",     v.cyc, 32'(rd_a_addr), v.rd_a);
        checkOutput("tbl.rd_b",     v.cyc, 32'(rd_b_addr), v.rd_b);
        checkOutput("tbl.s_we",     v.cyc, 32'(s_we),      32'(v.s_we));
        checkOutput("tbl.s_addr",   v.cyc, 32'(s_addr),    v.s_addr);
        checkOutput("tbl.done",     v.cyc, 32'(done),      32'(v.done));
        checkOutput("tbl.out_addr", v.cyc, 32'(out_addr),  v.out_addr);
        checkOutput("tbl.fin",      v.cyc, 32'(fin),       32'(v.fin));
    endtask

    // One complete run; cycle 0 is the first cycle after the preceding negedge in IDLE.
    task automatic doRun(input string tag, input bit use_tbl, input int gap, input int ovr_cyc,
                         input bit err_start);
        int tix = 0;
        int sent = 0;
        int ld_n = 0;
        int swe_n = 0;
        int done_n = 0;
        bit en_cur = 1'b0;
        bit fin_seen = 1'b0;
        bit finished = 1'b0;
        int limit = 1100 + gap;
        $display("[TB] run %s", tag);
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            @(negedge clk);
            if (use_tbl) begin
                if (tix < NVEC && tbl[tix].cyc == cyc) en_cur = tbl[tix].en;
            end else begin
                en_cur = (sent < NN && !(cyc > 20 && cyc <= 20 + gap)) || cyc == ovr_cyc;
            end
            if (en_cur && sent < NN && cyc != ovr_cyc) sent++;
            applyStimulus(en_cur);
            #1;
            if (fin_seen) begin
                checkOutput({tag, ".busy_after_fin"}, cyc, 32'(busy), 0);
                checkOutput({tag, ".fin_width"},      cyc, 32'(fin), 0);
                finished = 1'b1;
            end
            if (use_tbl && tix < NVEC && tbl[tix].cyc == cyc) begin
                checkVec(tbl[tix]);
                tix++;
            end
            if (ld_we) begin
                checkOutput({tag, ".ld_seq"}, cyc, 32'(ld_addr), ld_n);
                ld_n++;
            end
            if (s_we) begin
                checkOutput({tag, ".s_we_cycle"}, cyc, cyc, 73 + gap + 8 * swe_n);
                checkOutput({tag, ".s_addr"},     cyc, 32'(s_addr), swe_n);
                swe_n++;
            end
            if (done) begin
                checkOutput({tag, ".done_cycle"}, cyc, cyc, 587 + gap + 8 * done_n);
                checkOutput({tag, ".out_addr"},   cyc, 32'(out_addr), done_n);
                done_n++;
            end
            if (fin && !fin_seen) begin
                checkOutput({tag, ".fin_cycle"},   cyc, cyc, 1092 + gap);
                checkOutput({tag, ".err_at_fin"},  cyc, 32'(err_overrun), 32'(ovr_cyc >= 0));
                fin_seen = 1'b1;
            end
            if (cyc == 0) checkOutput({tag, ".err_start"}, cyc, 32'(err_overrun), 32'(err_start));
            if (cyc == 1) checkOutput({tag, ".err_clear"}, cyc, 32'(err_overrun), 0);
            if (gap > 0 && cyc > 20 && cyc <= 20 + gap) begin
                checkOutput({tag, ".gap_ld_we"},   cyc, 32'(ld_we), 0);
                checkOutput({tag, ".gap_ld_addr"}, cyc, 32'(ld_addr), 21);
            end
            if (cyc == 63 + gap) checkOutput({tag, ".pre_qk_mac_en"}, cyc, 32'(mac_en), 0);
            if (cyc == 64 + gap) begin
                checkOutput({tag, ".qk_start_mac_en"},  cyc, 32'(mac_en), 1);
                checkOutput({tag, ".qk_start_mac_clr"}, cyc, 32'(mac_clr), 1);
            end
            if (ovr_cyc >= 0 && cyc == ovr_cyc)
                checkOutput({tag, ".ovr_ld_we"}, cyc, 32'(ld_we), 0);
            if (ovr_cyc >= 0 && cyc == ovr_cyc + 1)
                checkOutput({tag, ".ovr_err"}, cyc, 32'(err_overrun), 1);
        end
        checkOutput({tag, ".finished"},  limit, 32'(finished), 1);
        checkOutput({tag, ".ld_count"},  limit, ld_n, NN);
        checkOutput({tag, ".swe_count"}, limit, swe_n, NN);
        checkOutput({tag, ".done_count"}, limit, done_n, NN);
        applyStimulus(1'b0);
    endtask

    initial begin
        //                cyc  en lw la  b me mc os ra  rb sw sa d  oa f
        tbl[0]  = mkVec(   0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mkVec(   1, 1, 1, 1,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mkVec(  63, 1, 1, 63, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[3]  = mkVec(  64, 0, 0, 0,  1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[4]  = mkVec(  65, 0, 0, 0,  1, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tbl[5]  = mkVec(  72, 0, 0, 0,  1, 1, 1, 0, 0,  8, 0, 0, 0, 0, 0);
        tbl[6]  = mkVec(  73, 0, 0, 0,  1, 1, 0, 0, 1,  9, 1, 0, 0, 0, 0);
        tbl[7]  = mkVec( 235, 0, 0, 0,  1, 1, 0, 0, 19, 43, 0, 0, 0, 0, 0);
        tbl[8]  = mkVec( 575, 0, 0, 0,  1, 1, 0, 0, 63, 63, 0, 0, 0, 0, 0);
        tbl[9]  = mkVec( 576, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[10] = mkVec( 577, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 63, 0, 0, 0);
        tbl[11] = mkVec( 578, 0, 0, 0,  1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        tbl[12] = mkVec( 579, 0, 0, 0,  1, 1, 0, 1, 1,  8, 0, 0, 0, 0, 0);
        tbl[13] = mkVec( 587, 0, 0, 0,  1, 1, 0, 1, 1,  9, 0, 0, 1, 0, 0);
        tbl[14] = mkVec( 746, 0, 0, 0,  1, 1, 1, 1, 16, 5, 0, 0, 0, 0, 0);
        tbl[15] = mkVec( 749, 0, 0, 0,  1, 1, 0, 1, 19, 29, 0, 0, 0, 0, 0);
        tbl[16] = mkVec(1089, 0, 0, 0,  1, 1, 0, 1, 63, 63, 0, 0, 0, 0, 0);
        tbl[17] = mkVec(1090, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[18] = mkVec(1091, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1, 63, 0);
        tbl[19] = mkVec(1092, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[20] = mkVec(1093, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        #1 reset = 1'b0;
        applyStimulus(1'b0);
        repeat (2) @(negedge clk);
        #1 checkZero("reset");
        @(negedge clk);
        reset = 1'b1;

        doRun("contiguous", 1'b1, 0, -1, 1'b0);
        doRun("gapped", 1'b0, 5, -1, 1'b0);
        doRun("overrun", 1'b0, 0, 700, 1'b0);
        doRun("after_overrun", 1'b0, 0, -1, 1'b1);

        // Abort during QK at issue 100, then a clean run must restart from address 0.
        $display("[TB] run abort");
        for (int cyc = 0; cyc <= 164; cyc++) begin
            @(negedge clk);
            applyStimulus(cyc < 64);
            #1;
        end
        checkOutput("abort.pre_mac_en", 164, 32'(mac_en), 1);
        checkOutput("abort.pre_rd_a",   164, 32'(rd_a_addr), 12);
        reset = 1'b0;
        #1 checkZero("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        doRun("post_abort", 1'b0, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
